iterative_muldiv: RTL and testbench

Multi-cycle unsigned multiply/divide unit for KGP-RISC, directly downstream of register_file. It consumes read_data1/read_data2 as operands and produces a 64-bit result plus the destination register tag for the write-back path feeding register_file write_reg/write_data. It uses one shift-add or restoring-division iteration per clock, and a start/busy/done handshake stalls issue while busy.

---
 rtl/muldiv_pkg.sv | 15 +
 rtl/iterative_muldiv_if.sv | 27 ++
 rtl/muldiv_step.sv | 36 +++
 rtl/iterative_muldiv.sv | 102 ++++++++++
 tb/tb_iterative_muldiv.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared constants and state encoding for the iterative multiply/divide unit
package muldiv_pkg;

    localparam logic        OP_MUL        = 1'b0;
    localparam logic        OP_DIV        = 1'b1;
    localparam int          MULDIV_WIDTH  = 32;
    localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/iterative_muldiv_if.sv
// rtl/iterative_muldiv_if.sv - issue/result handshake between register file and muldiv unit
interface iterative_muldiv_if #(
    parameter int WIDTH      = 32,
    parameter int REG_ADDR_W = 5
);
    logic                  start;
    logic                  op;
    logic [WIDTH-1:0]      operand_a;
    logic [WIDTH-1:0]      operand_b;
    logic [REG_ADDR_W-1:0] dest_reg;
    logic                  busy;
    logic                  done;
    logic [WIDTH-1:0]      result_lo;
    logic [WIDTH-1:0]      result_hi;
    logic [REG_ADDR_W-1:0] result_reg;
    logic                  div_by_zero;

    modport master (
        output start, op, operand_a, operand_b, dest_reg,
        input  busy, done, result_lo, result_hi, result_reg, div_by_zero
    );

    modport slave (
        input  start, op, operand_a, operand_b, dest_reg,
        output busy, done, result_lo, result_hi, result_reg, div_by_zero
    );
endinterface

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one combinational shift-add or restoring-division iteration
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             op,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] next_hi,
    output logic [WIDTH-1:0] next_lo
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   sh_r;
    logic [WIDTH-1:0] diff;

    // Remainder stays below the divisor, so WIDTH bits hold it between iterations.
    always_comb begin
        sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b} : '0);
        sh_r = {acc_hi, acc_lo[WIDTH-1]};
        diff = sh_r[WIDTH-1:0] - b;
        if (op == OP_MUL) begin
            next_hi = sum[WIDTH:1];
            next_lo = {sum[0], acc_lo[WIDTH-1:1]};
        end else if (sh_r >= {1'b0, b}) begin
            next_hi = diff;
            next_lo = {acc_lo[WIDTH-2:0], 1'b1};
        end else begin
            next_hi = sh_r[WIDTH-1:0];
            next_lo = {acc_lo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/iterative_muldiv.sv
// rtl/iterative_muldiv.sv - multi-cycle unsigned multiply/divide with start/busy/done handshake
module iterative_muldiv
    import muldiv_pkg::*;
#(
    parameter int WIDTH      = MULDIV_WIDTH,
    parameter int REG_ADDR_W = 5
) (
    input  logic clk,
    input  logic rst,
    iterative_muldiv_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH);

    state_e                state, state_nxt;
    logic [CNT_W-1:0]      count;
    logic                  op_q;
    logic [WIDTH-1:0]      b_q;
    logic [WIDTH-1:0]      acc_hi, acc_lo;
    logic [WIDTH-1:0]      step_hi, step_lo;
    logic [REG_ADDR_W-1:0] reg_q;
    logic                  div0;
    logic                  last_iter;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .op      (op_q),
        .acc_hi  (acc_hi),
        .acc_lo  (acc_lo),
        .b       (b_q),
        .next_hi (step_hi),
        .next_lo (step_lo)
    );

    // Divide-by-zero is resolved on the first CALC edge from the captured operands.
    assign div0      = (op_q == OP_DIV) && (b_q == '0) && (count == '0);
    assign last_iter = (count == CNT_W'(WIDTH - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (bus.start) state_nxt = ST_CALC;
            ST_CALC: if (div0 || last_iter) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= ST_IDLE;
            count           <= '0;
            op_q            <= OP_MUL;
            b_q             <= '0;
            acc_hi          <= '0;
            acc_lo          <= '0;
            reg_q           <= '0;
            bus.result_lo   <= '0;
            bus.result_hi   <= '0;
            bus.result_reg  <= '0;
            bus.div_by_zero <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        op_q   <= bus.op;
                        b_q    <= bus.operand_b;
                        acc_hi <= '0;
                        acc_lo <= bus.operand_a;
                        reg_q  <= bus.dest_reg;
                        count  <= '0;
                    end
                end
                ST_CALC: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    count  <= count + 1'b1;
                    if (div0) begin
                        bus.result_lo   <= '1;
                        bus.result_hi   <= acc_lo;
                        bus.result_reg  <= reg_q;
                        bus.div_by_zero <= 1'b1;
                    end else if (last_iter) begin
                        bus.result_lo   <= step_lo;
                        bus.result_hi   <= step_hi;
                        bus.result_reg  <= reg_q;
                        bus.div_by_zero <= 1'b0;
                    end
                end
                ST_DONE: begin
                    bus.div_by_zero <= 1'b0;
                    count           <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state != ST_IDLE);
    assign bus.done = (state == ST_DONE);

endmodule

// File: tb/tb_iterative_muldiv.sv
// tb/tb_iterative_muldiv.sv - scoreboard bench for iterative_muldiv
module tb_iterative_muldiv;

    typedef struct packed {
        logic [31:0] lo;
        logic [31:0] hi;
        logic [4:0]  rg;
        logic        dz;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   compared = 0;
    int   mismatched = 0;
    int   done_count = 0;
    exp_t sb[$];

    iterative_muldiv_if #(.WIDTH(32), .REG_ADDR_W(5)) bus ();

    iterative_muldiv #(.WIDTH(32), .REG_ADDR_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bus.done) done_count++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns just after the accepting edge E0.
    task automatic issue(input logic o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] d, input bit push);
        exp_t e;
        logic [63:0] p;
        if (o == 1'b0) begin
            p = {32'd0, a} * {32'd0, b};
            e = '{lo: p[31:0], hi: p[63:32], rg: d, dz: 1'b0};
        end else if (b == 32'd0) begin
            e = '{lo: 32'hFFFF_FFFF, hi: a, rg: d, dz: 1'b1};
        end else begin
            e = '{lo: a / b, hi: a % b, rg: d, dz: 1'b0};
        end
        if (push) sb.push_back(e);
        bus.op        = o;
        bus.operand_a = a;
        bus.operand_b = b;
        bus.dest_reg  = d;
        bus.start     = 1'b1;
        @(posedge clk);
        #1;
        bus.start     = 1'b0;
        bus.operand_a = $urandom;
        bus.operand_b = $urandom;
        bus.dest_reg  = 5'($urandom);
    endtask

    task automatic await_done(input int exp_edges, input string tag);
        int   edges = 0;
        bit   got = 0;
        exp_t e;
        while (!got && edges < 200) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (bus.done) got = 1;
        end
        chk({tag, "_latency"}, 64'(edges), 64'(exp_edges));
        if (got) begin
            if (sb.size() == 0) begin
                chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
            end else begin
                e = sb.pop_front();
                chk({tag, "_lo"},  64'(bus.result_lo),   64'(e.lo));
                chk({tag, "_hi"},  64'(bus.result_hi),   64'(e.hi));
                chk({tag, "_reg"}, 64'(bus.result_reg),  64'(e.rg));
                chk({tag, "_dz"},  64'(bus.div_by_zero), 64'(e.dz));
            end
            @(posedge clk);
            @(negedge clk);
            chk({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
            chk({tag, "_dz_pulse"},   64'(bus.div_by_zero), 64'd0);
            chk({tag, "_idle"},       64'(bus.busy), 64'd0);
        end
    endtask

    initial begin
        int dc;
        logic [31:0] ra, rb;
        bus.start = 1'b0; bus.op = 1'b0; bus.operand_a = '0; bus.operand_b = '0; bus.dest_reg = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_res",  {bus.result_hi, bus.result_lo}, 64'd0);
        chk("rst_reg",  64'({bus.result_reg, bus.div_by_zero}), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        issue(1'b0, 32'd7, 32'd6, 5'd3, 1); await_done(32, "mul_7x6");
        issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31, 1); await_done(32, "mul_max");
        issue(1'b1, 32'd100, 32'd7, 5'd4, 1); await_done(32, "div_100_7");
        issue(1'b1, 32'd5, 32'd9, 5'd5, 1); await_done(32, "div_5_9");
        issue(1'b1, 32'd5, 32'd0, 5'd6, 1); await_done(1, "div_5_0");
        issue(1'b1, 32'hFFFF_FFFF, 32'd1, 5'd8, 1); await_done(32, "div_max_1");
        for (int i = 0; i < 4; i++) begin
            ra = $urandom; rb = $urandom >> (i * 8);
            issue(i[0], ra, rb, 5'(i + 10), 1); await_done(32, "rand");
        end

        // Restart attempt while busy must be ignored.
        dc = done_count;
        issue(1'b0, 32'd1234, 32'd5678, 5'd9, 1);
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("restart_busy", 64'(bus.busy), 64'd1);
            bus.start     = (i >= 9 && i < 14);
            bus.op        = 1'b1;
            bus.operand_a = 32'd99;
            bus.operand_b = 32'd0;
            bus.dest_reg  = 5'd1;
        end
        await_done(17, "restart");
        chk("restart_one_done", 64'(done_count - dc), 64'd1);

        // Asynchronous reset mid-divide aborts with no done.
        issue(1'b1, 32'd1000, 32'd3, 5'd7, 0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        dc = done_count;
        #2 rst = 1'b0;
        #1;
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_res",  {bus.result_hi, bus.result_lo}, 64'd0);
        chk("abort_reg",  64'({bus.result_reg, bus.div_by_zero, bus.done}), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        chk("abort_no_done", 64'(done_count - dc), 64'd0);
        chk("abort_idle", 64'(bus.busy), 64'd0);

        issue(1'b0, 32'd3, 32'd4, 5'd2, 1); await_done(32, "mul_3x4");
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
